contador_tempo: RTL and testbench
=================================

CONTADOR_TEMPO -- requirements
Module: contador_tempo

Interface
REQ-001 The module SHALL have one parameter: MIN_MAX, default 9, the largest minutes digit accepted at load (range 1..9).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port tick_1hz, input, 1, one-cycle enable pulse, once per second.
REQ-005 The module SHALL have port digit, input, 4, keypad value to load; only values 0..9 are valid.
REQ-006 The module SHALL have port key_valid, input, 1, keypad strobe, level held for any number of cycles.
REQ-007 The module SHALL have port clearn, input, 1, active-low clear button, sampled synchronously.
REQ-008 The module SHALL have port mag_on, input, 1, magnetron-active level from the magnetron controller; it enables countdown.
REQ-009 The module SHALL have port min_ones, output, 4, BCD minutes digit.
REQ-010 The module SHALL have port sec_tens, output, 4, BCD tens-of-seconds digit, always 0..5.
REQ-011 The module SHALL have port sec_ones, output, 4, BCD seconds digit, always 0..9.
REQ-012 The module SHALL have port timer_done, output, 1, registered level; high when the count is 0:00.
REQ-013 The module SHALL have port done_pulse, output, 1, registered one-cycle pulse when a countdown reaches 0:00.

Function
REQ-014 The block SHALL hold the time M:ST in three BCD registers; all outputs are registered, with no combinational path from inputs to outputs.
REQ-015 The block SHALL register key_valid and detect its rising edge (key_valid=1, previous=0); exactly one load per rising edge.
REQ-016 State LOAD (mag_on=0): on a key edge with digit<=9, the block SHALL shift min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
REQ-017 The block SHALL ignore (no state change) a shift whose new sec_tens (old sec_ones) >5, or whose new min_ones (old sec_tens) >MIN_MAX.
REQ-018 The block SHALL ignore a digit >9, and any key edge while mag_on=1.
REQ-019 State COUNT (mag_on=1, count nonzero): on tick_1hz, the block SHALL decrement the count by one second with BCD borrow.
REQ-020 For the decrement: sec_ones 0->9 borrows from sec_tens; sec_tens 0->5 borrows from min_ones.
REQ-021 The block SHALL ignore tick_1hz when mag_on=0 (pause) or the count is 0:00 (no wrap to 9:59).
REQ-022 The block SHALL set timer_done=1 in the same cycle the registers hold 0:00, and 0 otherwise; it updates together with the digit registers.
REQ-023 The block SHALL assert done_pulse for exactly one cycle, in the cycle after the tick that changes the count from 0:01 to 0:00; never on load or clear.
REQ-024 When clearn=0, the block SHALL set all digits to 0 in the next cycle, set timer_done=1 and done_pulse=0, regardless of mag_on, tick or key.
REQ-025 Priority SHALL be reset > clearn > tick decrement > key load; tick and key in the same cycle cannot conflict because of mag_on gating.
REQ-026 If mag_on falls mid-count, the block SHALL freeze the count; a later rise of mag_on resumes from the frozen value.

Reset
REQ-027 With reset=1 at a clock edge, the block SHALL set min_ones=0, sec_tens=0, sec_ones=0, timer_done=1, done_pulse=0, and key edge register=0.
REQ-028 Reset SHALL override all other inputs; a key_valid held through reset release SHALL NOT cause a load.

Verification
REQ-029 Reset, then key edges 1,3,0 with mag_on=0 -> display 1:30, timer_done=0 after the third load.
REQ-030 From 1:30: mag_on=1, 31 ticks -> 0:59 after tick 31; borrow path 1:00->0:59 checked.
REQ-031 From 0:02: mag_on=1, 2 ticks -> 0:00, timer_done=1, done_pulse high exactly one cycle; a 3rd tick leaves 0:00, no pulse.
REQ-032 From 0:45 counting: mag_on=0 for 5 ticks -> 0:45 held; mag_on=1 and 1 tick -> 0:44.
REQ-033 key_valid held 4 cycles with digit=7 -> one shift only; digits 7 then 8 from 0:07 -> 0:07 held (sec_tens 7 is rejected); digit=12 -> ignored.
REQ-034 clearn=0 asserted in the same cycle as tick_1hz, at 2:15 while mag_on=1 -> 0:00, timer_done=1, done_pulse=0.

Source files
------------

// File: rtl/contador_tempo.sv
// contador_tempo: keypad-loaded M:SS BCD countdown timer
// gated by the magnetron-active level, with done level and pulse.
module contador_tempo #(
  parameter int MIN_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [3:0] digit,
  input  logic       key_valid,
  input  logic       clearn,
  input  logic       mag_on,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       done_pulse
);

  localparam logic [3:0] MAX_D = 4'(MIN_MAX);

  logic       key_q;
  logic       key_arm;
  logic       key_rise;
  logic       is_zero;
  logic       is_one;
  logic       do_dec;
  logic       do_load;
  logic [3:0] nx_min;
  logic [3:0] nx_ten;
  logic [3:0] nx_one;
  logic       nx_done;
  logic       nx_pulse;

  // key_arm stays low after reset until key_valid is seen low,
  // so a key held through reset release never loads.
  assign key_rise = key_valid & ~key_q & key_arm;

  assign is_zero = (min_ones == 4'd0) &&
                   (sec_tens == 4'd0) &&
                   (sec_ones == 4'd0);

  assign is_one = (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) &&
                  (sec_ones == 4'd1);

  assign do_dec = mag_on & tick_1hz & ~is_zero;

  assign do_load = ~mag_on & key_rise &
                   (digit <= 4'd9) &
                   (sec_ones <= 4'd5) &
                   (sec_tens <= MAX_D);

  // Keypad strobe history for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q   <= 1'b0;
      key_arm <= 1'b0;
    end else begin
      key_q   <= key_valid;
      key_arm <= key_arm | ~key_valid;
    end
  end

  // Next count: clear beats decrement beats load
  always_comb begin
    nx_min   = min_ones;
    nx_ten   = sec_tens;
    nx_one   = sec_ones;
    nx_done  = timer_done;
    nx_pulse = 1'b0;
    if (!clearn) begin
      nx_min  = 4'd0;
      nx_ten  = 4'd0;
      nx_one  = 4'd0;
      nx_done = 1'b1;
    end else if (do_dec) begin
      if (sec_ones != 4'd0) begin
        nx_one = sec_ones - 4'd1;
      end else begin
        nx_one = 4'd9;
        if (sec_tens != 4'd0) begin
          nx_ten = sec_tens - 4'd1;
        end else begin
          nx_ten = 4'd5;
          nx_min = min_ones - 4'd1;
        end
      end
      nx_done  = is_one;
      nx_pulse = is_one;
    end else if (do_load) begin
      nx_min  = sec_tens;
      nx_ten  = sec_ones;
      nx_one  = digit;
      nx_done = (sec_tens == 4'd0) &&
                (sec_ones == 4'd0) &&
                (digit == 4'd0);
    end
  end

  // Digit, done level and done pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      timer_done <= 1'b1;
      done_pulse <= 1'b0;
    end else begin
      min_ones   <= nx_min;
      sec_tens   <= nx_ten;
      sec_ones   <= nx_one;
      timer_done <= nx_done;
      done_pulse <= nx_pulse;
    end
  end

endmodule

// File: tb/tb_contador_tempo.sv
// tb_contador_tempo: directed scenarios plus random stimulus
// against a seconds-count reference model.
module tb_contador_tempo;

  localparam int MIN_MAX = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [3:0] digit;
  logic       key_valid;
  logic       clearn;
  logic       mag_on;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       timer_done;
  logic       done_pulse;

  contador_tempo #(.MIN_MAX(MIN_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .digit      (digit),
    .key_valid  (key_valid),
    .clearn     (clearn),
    .mag_on     (mag_on),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .timer_done (timer_done),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model state: total seconds remaining
  int total = 0;
  bit m_done = 1'b1;
  bit m_pulse = 1'b0;
  bit m_prev = 1'b0;
  bit m_armed = 1'b0;
  bit mag = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit c,
                       input bit t, input bit m,
                       input bit k, input int d);
    bit rise;
    int mm, tt, ss;
    if (r) begin
      total = 0; m_done = 1; m_pulse = 0;
      m_prev = 0; m_armed = 0;
      return;
    end
    rise = k && !m_prev && m_armed;
    m_prev = k;
    if (!k) m_armed = 1;
    m_pulse = 0;
    if (!c) begin
      total = 0; m_done = 1;
    end else if (m && t && total > 0) begin
      m_pulse = (total == 1);
      total--;
      m_done = (total == 0);
    end else if (!m && rise && d <= 9) begin
      mm = total / 60;
      tt = (total % 60) / 10;
      ss = total % 10;
      if (ss <= 5 && tt <= MIN_MAX) begin
        total = tt * 60 + ss * 10 + d;
        m_done = (total == 0);
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c,
                     input bit t, input bit m,
                     input bit k, input int d);
    reset = r; clearn = c; tick_1hz = t;
    mag_on = m; key_valid = k; digit = 4'(d);
    @(posedge clk);
    model(r, c, t, m, k, d);
    #1;
    chk("min_ones", 32'(min_ones), 32'(total / 60));
    chk("sec_tens", 32'(sec_tens), 32'((total % 60) / 10));
    chk("sec_ones", 32'(sec_ones), 32'(total % 10));
    chk("timer_done", 32'(timer_done), 32'(m_done));
    chk("done_pulse", 32'(done_pulse), 32'(m_pulse));
  endtask

  task automatic idle();
    cyc(0, 1, 0, mag, 0, 0);
  endtask

  task automatic press(input int d);
    cyc(0, 1, 0, mag, 1, d);
    cyc(0, 1, 0, mag, 0, d);
  endtask

  task automatic tick();
    cyc(0, 1, 1, mag, 0, 0);
  endtask

  task automatic clr();
    cyc(0, 0, 0, mag, 0, 0);
  endtask

  function automatic int disp();
    return int'(min_ones) * 100 + int'(sec_tens) * 10 +
           int'(sec_ones);
  endfunction

  initial begin
    reset = 1; clearn = 1; tick_1hz = 0;
    mag_on = 0; key_valid = 0; digit = 0;

    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 5);
    chk("rst_disp", 32'(disp()), 32'd0);
    chk("rst_done", 32'(timer_done), 32'd1);
    chk("rst_pulse", 32'(done_pulse), 32'd0);

    // key held across reset release: no load
    cyc(0, 1, 0, 0, 1, 5);
    cyc(0, 1, 0, 0, 1, 5);
    chk("held_rst", 32'(disp()), 32'd0);
    idle();

    mag = 0;
    press(1); press(3); press(0);
    chk("load_130", 32'(disp()), 32'd130);
    chk("load_done", 32'(timer_done), 32'd0);

    mag = 1;
    for (int i = 0; i < 30; i++) begin
      tick(); idle();
    end
    chk("at_100", 32'(disp()), 32'd100);
    tick();
    chk("borrow_059", 32'(disp()), 32'd59);
    idle();

    mag = 0; clr();
    press(2);
    chk("load_002", 32'(disp()), 32'd2);
    mag = 1;
    tick(); idle();
    tick();
    chk("zero_disp", 32'(disp()), 32'd0);
    chk("zero_done", 32'(timer_done), 32'd1);
    chk("pulse_hi", 32'(done_pulse), 32'd1);
    idle();
    chk("pulse_lo", 32'(done_pulse), 32'd0);
    tick();
    chk("no_wrap", 32'(disp()), 32'd0);
    chk("no_pulse", 32'(done_pulse), 32'd0);

    mag = 0; clr();
    press(4); press(5);
    mag = 1; idle();
    mag = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); idle();
    end
    chk("paused_045", 32'(disp()), 32'd45);
    mag = 1; tick();
    chk("resume_044", 32'(disp()), 32'd44);

    mag = 0; clr();
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 1, 7);
    idle();
    chk("held_007", 32'(disp()), 32'd7);
    press(8);
    chk("rej_ten", 32'(disp()), 32'd7);
    press(12);
    chk("rej_d12", 32'(disp()), 32'd7);

    clr();
    press(2); press(1); press(5);
    chk("load_215", 32'(disp()), 32'd215);
    mag = 1;
    cyc(0, 0, 1, 1, 0, 0);
    chk("clr_disp", 32'(disp()), 32'd0);
    chk("clr_done", 32'(timer_done), 32'd1);
    chk("clr_pulse", 32'(done_pulse), 32'd0);

    // random phase
    mag = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r, c, t, k;
      if ($urandom_range(0, 29) == 0) mag = ~mag;
      r = ($urandom_range(0, 399) == 0);
      c = ($urandom_range(0, 79) != 0);
      t = ($urandom_range(0, 2) == 0);
      k = ($urandom_range(0, 1) == 0);
      cyc(r, c, t, mag, k, int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
